// File: rtl/keystroke_encoder.sv
// PS/2 keyboard receiver that reports released letter keys as codes 1..26.
// Latency: kr rises on the cycle after the synchronized stop-bit falling edge.
// No backpressure: kr and frame_err are single-cycle pulses, kstrk holds until the next letter.
module keystroke_encoder #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] kstrk,
  output logic       kr,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_last;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tcnt;
  logic          par_bit;
  logic          par_ok;
  logic          break_pend;
  logic          ext_pend;
  logic [4:0]    letter_code;

  // Set-2 scan code to alphabet index; 0 means "not a letter".
  function automatic logic [4:0] letter(input logic [7:0] code);
    case (code)
      8'h1C: letter = 5'd1;   8'h32: letter = 5'd2;   8'h21: letter = 5'd3;
      8'h23: letter = 5'd4;   8'h24: letter = 5'd5;   8'h2B: letter = 5'd6;
      8'h34: letter = 5'd7;   8'h33: letter = 5'd8;   8'h43: letter = 5'd9;
      8'h3B: letter = 5'd10;  8'h42: letter = 5'd11;  8'h4B: letter = 5'd12;
      8'h3A: letter = 5'd13;  8'h31: letter = 5'd14;  8'h44: letter = 5'd15;
      8'h4D: letter = 5'd16;  8'h15: letter = 5'd17;  8'h2D: letter = 5'd18;
      8'h1B: letter = 5'd19;  8'h2C: letter = 5'd20;  8'h3C: letter = 5'd21;
      8'h2A: letter = 5'd22;  8'h1D: letter = 5'd23;  8'h22: letter = 5'd24;
      8'h35: letter = 5'd25;  8'h1A: letter = 5'd26;
      default: letter = 5'd0;
    endcase
  endfunction

  assign fall        = clk_last & ~clk_s2;
  assign par_ok      = ^{shreg, par_bit};
  assign letter_code = letter(shreg);

  // Two-flop synchronizers plus edge-history flop; idle level is 1 so reset release is edge-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_last <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_last <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  // Frame receiver, inactivity timeout and break/extended-prefix decoder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      tcnt       <= '0;
      par_bit    <= 1'b0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      kstrk      <= 5'd0;
      kr         <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      kr        <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (fall && !dat_s2) begin
          state   <= DATA;
          bit_cnt <= 3'd0;
        end
      end else if (fall) begin
        tcnt <= '0;
        case (state)
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && par_ok) begin
              if (shreg == 8'hF0) begin
                break_pend <= 1'b1;
              end else if (shreg == 8'hE0) begin
                ext_pend <= 1'b1;
              end else if (ext_pend) begin
                // Extended keys are never letters: swallow the whole sequence.
                ext_pend   <= 1'b0;
                break_pend <= 1'b0;
              end else if (break_pend) begin
                break_pend <= 1'b0;
                if (letter_code != 5'd0) begin
                  kstrk <= letter_code;
                  kr    <= 1'b1;
                end
              end
            end else begin
              // Bad byte is dropped; pending prefixes survive the error.
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
        state     <= IDLE;
        tcnt      <= '0;
        frame_err <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule
